// File: rtl/framebuffer_ctrl.sv
// Framebuffer controller: a single-port-write / single-port-read pixel store
// with a background clear engine, a client write port with range checking,
// and an upscaling display read path with a 2-cycle x/y -> RGB latency.
module framebuffer_ctrl #(
  parameter int unsigned FB_W        = 160,
  parameter int unsigned FB_H        = 120,
  parameter int unsigned SCALE_SHIFT = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       active,
  output logic [1:0] R,
  output logic [1:0] G,
  output logic [1:0] B,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_x,
  input  logic [6:0] wr_y,
  input  logic [5:0] wr_color,
  input  logic       clr_start,
  input  logic [5:0] clr_color,
  output logic       busy,
  output logic       clr_done,
  output logic [7:0] drop_cnt
);

  localparam int unsigned Depth = FB_W * FB_H;
  localparam int unsigned AW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AW-1:0] LastAddr = AW'(Depth - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e          state_q;
  logic [AW-1:0]   clr_addr_q;
  logic [5:0]      clr_color_q;
  logic [7:0]      drop_cnt_q;

  logic [5:0]      mem [Depth];
  logic [5:0]      rd_data_q;
  logic            qual_q;
  logic [5:0]      rgb_q;

  logic            wr_accept;
  logic            wr_in_range;
  logic [AW-1:0]   wr_addr;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [5:0]      mem_wdata;

  logic [9:0]      x_fb;
  logic [9:0]      y_fb;
  logic            rd_in_range;
  logic            pix_qual;
  logic [AW-1:0]   rd_addr;

  // Client handshake and status; reset and a pending clear both block writes.
  assign wr_ready  = reset && (state_q == StIdle) && !clr_start;
  assign busy      = (state_q == StClear);
  assign clr_done  = reset && busy && (clr_addr_q == LastAddr);
  assign drop_cnt  = drop_cnt_q;

  assign wr_accept   = wr_valid && wr_ready;
  assign wr_in_range = (32'(wr_x) < FB_W) && (32'(wr_y) < FB_H);
  assign wr_addr     = AW'(32'(wr_y) * FB_W + 32'(wr_x));

  // Display coordinates scaled down to framebuffer coordinates.
  assign x_fb        = x >> SCALE_SHIFT;
  assign y_fb        = y >> SCALE_SHIFT;
  assign rd_in_range = (32'(x_fb) < FB_W) && (32'(y_fb) < FB_H);
  assign pix_qual    = active && (x != 10'h3FF) && (y != 10'h3FF) && rd_in_range;
  // Out-of-range reads are masked downstream; clamping keeps the index inside the array.
  assign rd_addr     = rd_in_range ? AW'(32'(y_fb) * FB_W + 32'(x_fb)) : '0;

  // Write-port arbitration: the clear engine owns the port while running.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_color;
    if (reset && (state_q == StClear)) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr_q;
      mem_wdata = clr_color_q;
    end else if (wr_accept && wr_in_range) begin
      mem_we = 1'b1;
    end
  end

  // Control FSM: idle until a clear request, then sweep every address once.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q     <= StIdle;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (clr_start) begin
            state_q     <= StClear;
            clr_addr_q  <= '0;
            clr_color_q <= clr_color;
          end
        end
        StClear: begin
          if (clr_addr_q == LastAddr) begin
            state_q <= StIdle;
          end else begin
            clr_addr_q <= clr_addr_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Saturating counter of accepted writes that fall outside the framebuffer.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else if (wr_accept && !wr_in_range && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  // Pixel store: no reset; read is registered and sees the pre-write value.
  always_ff @(posedge CLOCK_50) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    rd_data_q <= mem[rd_addr];
  end

  // Output stage: qualifier tracks the read, colour forced to black when invalid.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      qual_q <= 1'b0;
      rgb_q  <= '0;
    end else begin
      qual_q <= pix_qual;
      rgb_q  <= qual_q ? rd_data_q : 6'b0;
    end
  end

  assign R = rgb_q[5:4];
  assign G = rgb_q[3:2];
  assign B = rgb_q[1:0];

endmodule

// File: tb/tb_framebuffer_ctrl.sv
// Directed self-checking bench for framebuffer_ctrl (default 160x120, 4x upscale).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_framebuffer_ctrl;

  logic       clk;
  logic       reset;
  logic [9:0] x;
  logic [9:0] y;
  logic       active;
  logic [1:0] R;
  logic [1:0] G;
  logic [1:0] B;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_x;
  logic [6:0] wr_y;
  logic [5:0] wr_color;
  logic       clr_start;
  logic [5:0] clr_color;
  logic       busy;
  logic       clr_done;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  framebuffer_ctrl dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .active    (active),
    .R         (R),
    .G         (G),
    .B         (B),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_color  (wr_color),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .busy      (busy),
    .clr_done  (clr_done),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One accepted write (wr_ready is high in idle with no clear pending).
  task automatic fb_write(input logic [7:0] wx, input logic [6:0] wy, input logic [5:0] c);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_x     = wx;
    wr_y     = wy;
    wr_color = c;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Present one display coordinate for a single cycle, return RGB two edges later.
  task automatic pixel(input logic [9:0] px, input logic [9:0] py, input logic act,
                       output logic [5:0] rgb);
    @(negedge clk);
    x      = px;
    y      = py;
    active = act;
    @(negedge clk);
    x      = 10'h3FF;
    y      = 10'h3FF;
    active = 1'b0;
    @(negedge clk);
    rgb = {R, G, B};
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] rgb;
    int n;
    int done_at;
    int done_cnt;
    int rdy_bad;

    reset     = 1'b0;
    x         = 10'h3FF;
    y         = 10'h3FF;
    active    = 1'b0;
    wr_valid  = 1'b1;
    wr_x      = 8'd1;
    wr_y      = 7'd1;
    wr_color  = 6'b111111;
    clr_start = 1'b0;
    clr_color = 6'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_wr_ready", wr_ready, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_clr_done", clr_done, 1'b0);
    check("reset_drop_cnt", drop_cnt, 8'd0);
    check("reset_rgb", {R, G, B}, 6'd0);
    wr_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    wr_valid = 1'b1;
    #1;
    check("idle_wr_ready", wr_ready, 1'b1);
    wr_valid = 1'b0;

    // Basic writes and upscaled reads
    fb_write(8'd5, 7'd3, 6'b110000);
    fb_write(8'd6, 7'd3, 6'b001100);
    fb_write(8'd0, 7'd1, 6'b010101);
    pixel(10'd20, 10'd12, 1'b1, rgb);
    check("px_20_12", rgb, 6'b110000);
    pixel(10'd23, 10'd15, 1'b1, rgb);
    check("px_23_15", rgb, 6'b110000);
    pixel(10'd24, 10'd12, 1'b1, rgb);
    check("px_24_12", rgb, 6'b001100);
    pixel(10'd0, 10'd4, 1'b1, rgb);
    check("px_0_4", rgb, 6'b010101);
    pixel(10'd20, 10'd12, 1'b0, rgb);
    check("px_inactive", rgb, 6'd0);
    pixel(10'h3FF, 10'd12, 1'b1, rgb);
    check("px_x3ff", rgb, 6'd0);
    pixel(10'd20, 10'h3FF, 1'b1, rgb);
    check("px_y3ff", rgb, 6'd0);
    pixel(10'd640, 10'd0, 1'b1, rgb);
    check("px_x_past_width", rgb, 6'd0);

    // Out-of-range writes are dropped and counted
    fb_write(8'd160, 7'd0, 6'b111111);
    fb_write(8'd0, 7'd120, 6'b111111);
    check("drop_cnt_2", drop_cnt, 8'd2);
    pixel(10'd0, 10'd4, 1'b1, rgb);
    check("drop_no_alias", rgb, 6'b010101);
    pixel(10'd20, 10'd12, 1'b1, rgb);
    check("drop_keep_5_3", rgb, 6'b110000);

    // Read-before-write on the same address
    @(negedge clk);
    x        = 10'd20;
    y        = 10'd12;
    active   = 1'b1;
    wr_valid = 1'b1;
    wr_x     = 8'd5;
    wr_y     = 7'd3;
    wr_color = 6'b001111;
    @(negedge clk);
    wr_valid = 1'b0;
    x        = 10'h3FF;
    y        = 10'h3FF;
    active   = 1'b0;
    @(negedge clk);
    check("rbw_old", {R, G, B}, 6'b110000);
    pixel(10'd20, 10'd12, 1'b1, rgb);
    check("rbw_new", rgb, 6'b001111);

    // Clear colliding with a write, plus an ignored restart mid-clear
    @(negedge clk);
    clr_start = 1'b1;
    clr_color = 6'b000011;
    wr_valid  = 1'b1;
    wr_x      = 8'd10;
    wr_y      = 7'd10;
    wr_color  = 6'b111111;
    #1;
    check("collide_wr_ready", wr_ready, 1'b0);
    @(negedge clk);
    clr_start = 1'b0;
    wr_valid  = 1'b0;
    clr_color = 6'b110000;
    n        = 0;
    done_at  = -1;
    done_cnt = 0;
    rdy_bad  = 0;
    while (busy && n < 20000) begin
      n++;
      clr_start = (n == 5000);
      #1;
      if (wr_ready) rdy_bad++;
      if (clr_done) begin
        done_at = n;
        done_cnt++;
      end
      @(negedge clk);
    end
    clr_start = 1'b0;
    check("clear_busy_cycles", n, 19200);
    check("clear_done_cycle", done_at, 19200);
    check("clear_done_pulses", done_cnt, 1);
    check("clear_wr_ready_low", rdy_bad, 0);
    check("clear_done_low_after", clr_done, 1'b0);
    pixel(10'd40, 10'd40, 1'b1, rgb);
    check("clear_lost_write", rgb, 6'b000011);
    pixel(10'd20, 10'd12, 1'b1, rgb);
    check("clear_5_3", rgb, 6'b000011);
    pixel(10'd636, 10'd476, 1'b1, rgb);
    check("clear_last", rgb, 6'b000011);
    pixel(10'd0, 10'd0, 1'b1, rgb);
    check("clear_first", rgb, 6'b000011);
    check("clear_keeps_drop", drop_cnt, 8'd2);

    // Drop counter increments and saturates
    @(negedge clk);
    wr_valid = 1'b1;
    wr_x     = 8'd200;
    wr_y     = 7'd0;
    repeat (10) @(negedge clk);
    wr_valid = 1'b0;
    check("drop_cnt_12", drop_cnt, 8'd12);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_x     = 8'd0;
    wr_y     = 7'd127;
    repeat (300) @(negedge clk);
    wr_valid = 1'b0;
    check("drop_cnt_sat", drop_cnt, 8'd255);

    // Reset aborts a clear at address 100
    @(negedge clk);
    clr_start = 1'b1;
    clr_color = 6'b110000;
    @(negedge clk);
    clr_start = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_wr_ready", wr_ready, 1'b0);
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_clr_done", clr_done, 1'b0);
    check("abort_drop_cnt", drop_cnt, 8'd0);
    reset = 1'b1;
    pixel(10'd0, 10'd0, 1'b1, rgb);
    check("abort_addr0", rgb, 6'b110000);
    pixel(10'd396, 10'd0, 1'b1, rgb);
    check("abort_addr99", rgb, 6'b110000);
    pixel(10'd400, 10'd0, 1'b1, rgb);
    check("abort_addr100", rgb, 6'b000011);
    pixel(10'd0, 10'd4, 1'b1, rgb);
    check("abort_addr160", rgb, 6'b000011);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
